// File: rtl/mul_ctrl_pkg.sv
// Shared EXE-stage definitions for the multi-cycle multiplier sequencer:
// operand width, multiply op encodings and controller states.
`ifndef RegW
`define RegW 32
`endif

package mul_ctrl_pkg;

    localparam int REG_W = `RegW;

    typedef enum logic [1:0] {
        MUL_W    = 2'd0,
        MULH_W   = 2'd1,
        MULH_WU  = 2'd2,
        MUL_RSVD = 2'd3
    } MulOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } MulState;

endpackage

// File: rtl/mul_ctrl_fix.sv
// Result word select for the signed Booth product, including the unsigned
// high-word correction. Shared by the normal completion path and the bypass.
module mul_fix
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN = REG_W
) (
    input  logic [1:0]        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [2*XLEN-1:0] product_i,
    output logic [XLEN-1:0]   result_o
);

    logic [XLEN-1:0] hiWord;
    logic [XLEN-1:0] loWord;
    logic [XLEN-1:0] unsignedCorr;

    // Signed product high word becomes the unsigned one by adding back each
    // operand wherever the other had its sign bit set.
    always_comb begin
        hiWord       = product_i[2*XLEN-1:XLEN];
        loWord       = product_i[XLEN-1:0];
        unsignedCorr = (a_i[XLEN-1] ? b_i : '0) + (b_i[XLEN-1] ? a_i : '0);
        case (MulOp'(op_i))
            MULH_W:  result_o = hiWord;
            MULH_WU: result_o = hiWord + unsignedCorr;
            default: result_o = loWord;
        endcase
    end

endmodule

// File: rtl/mul_ctrl.sv
// EXE-stage sequencer for the multi-cycle signed multiplier: request/response
// handshakes, start-level control, flush handling and a last-result bypass.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN      = REG_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [XLEN-1:0]   req_opd1_i,
    input  logic [XLEN-1:0]   req_opd2_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic              busy_o,
    output logic              mult_start_o,
    output logic [XLEN-1:0]   mult_opd1_o,
    output logic [XLEN-1:0]   mult_opd2_o,
    input  logic [2*XLEN-1:0] product_i,
    input  logic              mult_end_i
);

    MulState           state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   opdA_q, opdA_d;
    logic [XLEN-1:0]   opdB_q, opdB_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   respData_q, respData_d;
    logic              bypValid_q, bypValid_d;
    logic [XLEN-1:0]   bypA_q, bypA_d;
    logic [XLEN-1:0]   bypB_q, bypB_d;
    logic [2*XLEN-1:0] bypProd_q, bypProd_d;

    logic [XLEN-1:0]   fixResult;
    logic [XLEN-1:0]   bypResult;
    logic              bypHit;

    mul_fix #(.XLEN(XLEN)) u_fix (
        .op_i      (op_q),
        .a_i       (opdA_q),
        .b_i       (opdB_q),
        .product_i (prod_q),
        .result_o  (fixResult)
    );

    // The cached operands equal the request's, so the cached product with the
    // incoming op yields the same word a fresh multiply would.
    mul_fix #(.XLEN(XLEN)) u_bypFix (
        .op_i      (req_op_i),
        .a_i       (req_opd1_i),
        .b_i       (req_opd2_i),
        .product_i (bypProd_q),
        .result_o  (bypResult)
    );

    assign bypHit = BYPASS_EN && bypValid_q
                    && (bypA_q == req_opd1_i) && (bypB_q == req_opd2_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            opdA_q     <= '0;
            opdB_q     <= '0;
            prod_q     <= '0;
            respData_q <= '0;
            bypValid_q <= 1'b0;
            bypA_q     <= '0;
            bypB_q     <= '0;
            bypProd_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opdA_q     <= opdA_d;
            opdB_q     <= opdB_d;
            prod_q     <= prod_d;
            respData_q <= respData_d;
            bypValid_q <= bypValid_d;
            bypA_q     <= bypA_d;
            bypB_q     <= bypB_d;
            bypProd_q  <= bypProd_d;
        end
    end

    // Flush outranks everything; a flush with mult_end_i drops the product
    // and leaves the bypass entry untouched since FIX is never reached.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opdA_d     = opdA_q;
        opdB_d     = opdB_q;
        prod_d     = prod_q;
        respData_d = respData_q;
        bypValid_d = bypValid_q;
        bypA_d     = bypA_q;
        bypB_d     = bypB_q;
        bypProd_d  = bypProd_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    op_d   = req_op_i;
                    opdA_d = req_opd1_i;
                    opdB_d = req_opd2_i;
                    if (bypHit) begin
                        respData_d = bypResult;
                        state_d    = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (mult_end_i) begin
                    prod_d  = product_i;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    respData_d = fixResult;
                    bypValid_d = 1'b1;
                    bypA_d     = opdA_q;
                    bypB_d     = opdB_q;
                    bypProd_d  = prod_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (flush_i || resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign mult_start_o = (state_q == RUN);
    assign resp_valid_o = (state_q == DONE);
    assign resp_data_o  = respData_q;
    assign mult_opd1_o  = opdA_q;
    assign mult_opd2_o  = opdB_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed scoreboard bench for mul_ctrl with a variable-latency multiplier
// model; expected words come from a plain 64-bit reference multiply.
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = 2'd0;
    logic [W-1:0]  req_opd1_i = '0;
    logic [W-1:0]  req_opd2_i = '0;
    logic          flush_i = 1'b0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [W-1:0]  resp_data_o;
    logic          busy_o;
    logic          mult_start_o;
    logic [W-1:0]  mult_opd1_o;
    logic [W-1:0]  mult_opd2_o;
    logic [2*W-1:0] product_i = '0;
    logic          mult_end_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int mulLat = 4;
    int mulCnt = 0;
    int startCnt = 0;
    logic [W-1:0] expQ[$];

    mul_ctrl #(.XLEN(W), .BYPASS_EN(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_opd1_i   (req_opd1_i),
        .req_opd2_i   (req_opd2_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .busy_o       (busy_o),
        .mult_start_o (mult_start_o),
        .mult_opd1_o  (mult_opd1_o),
        .mult_opd2_o  (mult_opd2_o),
        .product_i    (product_i),
        .mult_end_i   (mult_end_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Multiplier model: counts start-high cycles, pulses end after mulLat of them.
    always @(negedge clk_i) begin
        if (!mult_start_o) begin
            mulCnt = 0;
            mult_end_i = 1'b0;
        end else begin
            startCnt = startCnt + 1;
            mulCnt = mulCnt + 1;
            if (mulCnt == mulLat) begin
                product_i = $signed({{W{mult_opd1_o[W-1]}}, mult_opd1_o})
                          * $signed({{W{mult_opd2_o[W-1]}}, mult_opd2_o});
                mult_end_i = 1'b1;
            end else begin
                mult_end_i = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] refModel(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, ps;
        logic [2*W-1:0] pu;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        ps = sa * sb;
        pu = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'd1:    return ps[2*W-1:W];
            2'd2:    return pu[2*W-1:W];
            default: return ps[W-1:0];
        endcase
    endfunction

    task automatic checkValue(input string tag, input logic [127:0] obs,
                              input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkValue(tag, {req_ready_o, resp_valid_o, resp_data_o, mult_start_o,
                         mult_opd1_o, mult_opd2_o, busy_o},
                   {1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0});
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit push);
        @(negedge clk_i);
        req_op_i    = op;
        req_opd1_i  = a;
        req_opd2_i  = b;
        req_valid_i = 1'b1;
        for (int i = 0; i < 50 && !req_ready_o; i++) @(negedge clk_i);
        checkValue("req_ready_before_accept", {127'h0, req_ready_o}, 128'h1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        acceptCyc = cyc;
        if (push) expQ.push_back(refModel(op, a, b));
    endtask

    task automatic checkOutput(input string tag, input int hold, input int expLat);
        int waited;
        logic [W-1:0] expv;
        waited = 0;
        @(negedge clk_i);
        while (!resp_valid_o && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        expv = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
        if (!resp_valid_o) begin
            checkValue({tag, "_valid_timeout"}, {127'h0, resp_valid_o}, 128'h1);
            return;
        end
        checkValue({tag, "_data"}, {96'h0, resp_data_o}, {96'h0, expv});
        if (expLat > 0)
            checkValue({tag, "_latency"}, cyc - acceptCyc + 1, expLat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            checkValue({tag, "_stall"}, {resp_valid_o, req_ready_o, resp_data_o},
                       {1'b1, 1'b0, expv});
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        checkValue({tag, "_after_handshake"},
                   {resp_valid_o, req_ready_o, mult_start_o, busy_o}, 4'b0100);
    endtask

    initial begin
        int s0;
        int sawValid;

        $display("[TB] reset");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        checkResetState("reset_state");

        $display("[TB] MUL.W 3 * -5");
        mulLat = 4;
        s0 = startCnt;
        applyStimulus(MUL_W, 32'd3, 32'hFFFF_FFFB, 1'b1);
        checkValue("mulw_operands", {mult_opd1_o, mult_opd2_o}, {32'd3, 32'hFFFF_FFFB});
        checkOutput("mulw_neg", 0, 6);
        checkValue("mulw_start_cycles", startCnt - s0, 4);
        checkValue("mulw_expected_const", {96'h0, refModel(MUL_W, 32'd3, 32'hFFFF_FFFB)},
                   {96'h0, 32'hFFFF_FFF1});

        $display("[TB] MULH.W / MULH.WU corners");
        mulLat = 2;
        applyStimulus(MULH_W, 32'h8000_0000, 32'h8000_0000, 1'b1);
        checkOutput("mulhw_min", 0, 4);
        mulLat = 5;
        applyStimulus(MULH_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checkOutput("mulhwu_max", 0, 7);

        $display("[TB] bypass hits");
        s0 = startCnt;
        applyStimulus(MULH_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checkOutput("byp_mulhwu", 0, 1);
        applyStimulus(MUL_W, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checkOutput("byp_mulw", 0, 1);
        checkValue("byp_no_start", startCnt - s0, 0);

        $display("[TB] flush during RUN");
        mulLat = 20;
        applyStimulus(MUL_W, 32'd5, 32'd5, 1'b0);
        repeat (4) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        checkValue("flush_run_idle", {mult_start_o, busy_o, resp_valid_o, req_ready_o}, 4'b0001);
        sawValid = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            if (resp_valid_o) sawValid++;
        end
        checkValue("flush_run_no_resp", sawValid, 0);
        mulLat = 3;
        applyStimulus(MUL_W, 32'd7, 32'd6, 1'b1);
        checkOutput("mulw_7x6", 0, 5);
        applyStimulus(MUL_RSVD, 32'd7, 32'd6, 1'b1);
        checkOutput("rsvd_bypass", 0, 1);

        $display("[TB] flush in IDLE blocks acceptance");
        @(negedge clk_i);
        req_op_i    = MUL_W;
        req_opd1_i  = 32'd7;
        req_opd2_i  = 32'd6;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        @(negedge clk_i);
        checkValue("flush_idle_blocked", {busy_o, resp_valid_o, req_ready_o}, 3'b001);

        $display("[TB] flush coincident with mult_end");
        mulLat = 3;
        applyStimulus(MULH_W, 32'd9, 32'd9, 1'b0);
        repeat (3) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        checkValue("flush_end_idle", {busy_o, resp_valid_o}, 2'b00);
        applyStimulus(MUL_W, 32'd9, 32'd9, 1'b1);
        checkOutput("mulw_9x9_nobyp", 0, 5);

        $display("[TB] response back-pressure");
        mulLat = 4;
        applyStimulus(MULH_W, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        checkOutput("stall10", 10, 6);

        $display("[TB] reset during RUN");
        mulLat = 20;
        applyStimulus(MUL_W, 32'd11, 32'd13, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkResetState("reset_mid_run");
        mulLat = 4;
        applyStimulus(MULH_WU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        checkOutput("post_reset_nobyp", 0, 6);

        checkValue("scoreboard_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
